// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and command layout for the ALU command sequencer.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MAX = 4'd8;

    localparam int ALU_W = 32;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    // Command layout at the native 32-bit ALU width.
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [3:0]       op;
    } cmd_t;

endpackage

// File: rtl/fifo_comenzi.sv
// Synchronous command FIFO; power-of-two depth so pointers wrap for free.
module fifo_comenzi #(
    parameter int DATA_W = 68,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; the level counter guards validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/alu_secventiator.sv
// Sequencer in front of the combinational ALU: queues commands, holds ALU
// inputs stable, and applies the error/remainder policy on capture.
module alu_secventiator
    import alu_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [W-1:0]           cmd_A,
    input  logic [W-1:0]           cmd_B,
    input  logic [3:0]             cmd_op,
    output logic [W-1:0]           alu_A,
    output logic [W-1:0]           alu_B,
    output logic [3:0]             alu_operatie,
    input  logic [W-1:0]           alu_rezultat,
    input  logic [W-1:0]           alu_rest,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [W-1:0]           rsp_rezultat,
    output logic [W-1:0]           rsp_rest,
    output logic                   rsp_zero,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] nivel
);
    localparam int CW = 2*W + 4;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [3:0]    op_q, op_d;
    logic          vld_q, vld_d, zero_q, zero_d, err_q, err_d;
    logic [W-1:0]  rez_q, rez_d, rest_q, rest_d;
    logic [W-1:0]  cap_rez, cap_rest;
    logic          cap_err;

    logic          f_push, f_pop, f_full, f_empty;
    logic [CW-1:0] f_dout;
    logic [W-1:0]  head_a, head_b;
    logic [3:0]    head_op;

    fifo_comenzi #(.DATA_W(CW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (f_push),
        .pop   (f_pop),
        .din   ({cmd_A, cmd_B, cmd_op}),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .level (nivel)
    );

    assign cmd_ready = !f_full;
    assign f_push    = cmd_valid && !f_full;
    assign {head_a, head_b, head_op} = f_dout;
    // Pop only when the ALU regs are free: idle, or the held response is leaving.
    assign f_pop = !f_empty && (state_q == IDLE || (state_q == RESP && rsp_ready));

    always_comb begin
        cap_rez  = alu_rezultat;
        cap_rest = '0;
        cap_err  = 1'b0;
        if (op_q > OP_MAX) begin
            cap_rez = '0;
            cap_err = 1'b1;
        end else if (op_q == OP_DIV && b_q == '0) begin
            cap_rez  = '1;
            cap_rest = a_q;
            cap_err  = 1'b1;
        end else if (op_q == OP_DIV) begin
            cap_rest = alu_rest;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        vld_d   = vld_q;
        rez_d   = rez_q;
        rest_d  = rest_q;
        zero_d  = zero_q;
        err_d   = err_q;
        if (f_pop) begin
            a_d  = head_a;
            b_d  = head_b;
            op_d = head_op;
        end
        case (state_q)
            IDLE: if (f_pop) state_d = EXEC;
            EXEC: begin
                vld_d   = 1'b1;
                rez_d   = cap_rez;
                rest_d  = cap_rest;
                zero_d  = (cap_rez == '0);
                err_d   = cap_err;
                state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                vld_d   = 1'b0;
                state_d = f_pop ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            vld_q   <= 1'b0;
            rez_q   <= '0;
            rest_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            vld_q   <= vld_d;
            rez_q   <= rez_d;
            rest_q  <= rest_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign alu_A        = a_q;
    assign alu_B        = b_q;
    assign alu_operatie = op_q;
    assign rsp_valid    = vld_q;
    assign rsp_rezultat = rez_q;
    assign rsp_rest     = rest_q;
    assign rsp_zero     = zero_q;
    assign rsp_err      = err_q;

endmodule
